// File: rtl/oven_temp_ctrl.sv
// Oven temperature sequencer.
// Takes a target temperature and cook time. It ramps the modelled oven temperature up to the
// target, holds it for the cook time, then ramps it back down to ambient.
// Optional feature: define PREHEAT_DONE_EN to add the preheat_done output.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         one-cycle request, sampled only in IDLE
//   abort         level; cancels an INCREASE/HOLD cycle
//   target_temp   requested temperature (binary degrees), clamped to [AMBIENT, MAX_TEMP]
//   cook_min      hold duration in minutes
//   state         IDLE=0, INCREASE=1, HOLD=2, DECREASE=3
//   cur_temp      modelled oven temperature (binary)
//   temp_bcd      {hundreds, tens, ones} of cur_temp, one cycle behind
//   min_left      minutes remaining in HOLD, 0 elsewhere
//   heater_on     high in INCREASE and HOLD
//   done          one-cycle pulse on DECREASE -> IDLE
//   preheat_done  (PREHEAT_DONE_EN only) one-cycle pulse on INCREASE -> HOLD
module oven_temp_ctrl #(
   parameter int unsigned TICK_DIV    = 50000000,
   parameter int unsigned RAMP_STEP   = 5,
   parameter int unsigned AMBIENT     = 70,
   parameter int unsigned MAX_TEMP    = 500,
   parameter int unsigned SEC_PER_MIN = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [9:0]  target_temp,
   input  logic [7:0]  cook_min,
   output logic [2:0]  state,
   output logic [9:0]  cur_temp,
   output logic [11:0] temp_bcd,
   output logic [7:0]  min_left,
   output logic        heater_on,
   output logic        done
`ifdef PREHEAT_DONE_EN
   ,
   output logic        preheat_done
`endif
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StIncrease = 3'd1,
      StHold     = 3'd2,
      StDecrease = 3'd3
   } state_e;

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
   localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SecLast  = SW'(SEC_PER_MIN - 1);
   localparam logic [9:0]    Ambient  = 10'(AMBIENT);
   localparam logic [9:0]    MaxTemp  = 10'(MAX_TEMP);
   localparam logic [10:0]   Step11   = 11'(RAMP_STEP);
   localparam logic [10:0]   DownMin  = 11'(AMBIENT + RAMP_STEP);

   // Double-dabble conversion. Inputs are at most 999, so three digits are enough.
   function automatic logic [11:0] to_bcd(input logic [9:0] bin);
      logic [11:0] bcd;
      bcd = '0;
      for (int i = 9; i >= 0; i--) begin
         if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
         if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
         if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
         bcd = {bcd[10:0], bin[i]};
      end
      return bcd;
   endfunction

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [SW-1:0] sec_cnt_q, sec_cnt_d;
   logic [9:0]    tgt_q, tgt_d;
   logic [9:0]    cur_q, cur_d;
   logic [7:0]    min_q, min_d;
   logic          heater_q, heater_d;
   logic          done_q, done_d;
   logic          pre_q, pre_d;
   logic [11:0]   bcd_q;
   logic          tick;
   logic [10:0]   up_sum;

   assign tick   = (tick_cnt_q == TickLast);
   assign up_sum = {1'b0, cur_q} + Step11;

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      sec_cnt_d  = sec_cnt_q;
      tgt_d      = tgt_q;
      cur_d      = cur_q;
      min_d      = min_q;
      done_d     = 1'b0;
      pre_d      = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (target_temp < Ambient)      tgt_d = Ambient;
               else if (target_temp > MaxTemp) tgt_d = MaxTemp;
               else                            tgt_d = target_temp;
               min_d      = cook_min;
               sec_cnt_d  = '0;
               tick_cnt_d = '0;
               state_d    = StIncrease;
            end
         end
         StIncrease: begin
            if (abort) begin
               state_d   = StDecrease;
               min_d     = '0;
               sec_cnt_d = '0;
            end else if (cur_q == tgt_q) begin
               state_d = StHold;
               pre_d   = 1'b1;
            end else if (tick) begin
               cur_d = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[9:0];
            end
         end
         StHold: begin
            // abort takes priority over any tick in the same cycle
            if (abort) begin
               state_d   = StDecrease;
               min_d     = '0;
               sec_cnt_d = '0;
            end else if (min_q == 8'd0 && sec_cnt_q == '0) begin
               state_d = StDecrease;
            end else if (tick) begin
               if (sec_cnt_q == SecLast) begin
                  sec_cnt_d = '0;
                  min_d     = min_q - 8'd1;
               end else begin
                  sec_cnt_d = sec_cnt_q + SW'(1);
               end
            end
         end
         StDecrease: begin
            if (cur_q == Ambient) begin
               state_d = StIdle;
               done_d  = 1'b1;
               min_d   = '0;
            end else if (tick) begin
               cur_d = ({1'b0, cur_q} >= DownMin) ? cur_q - 10'(RAMP_STEP) : Ambient;
            end
         end
         default: state_d = StIdle;
      endcase

      heater_d = (state_d == StIncrease) || (state_d == StHold);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         tick_cnt_q <= '0;
         sec_cnt_q  <= '0;
         tgt_q      <= Ambient;
         cur_q      <= Ambient;
         min_q      <= '0;
         heater_q   <= 1'b0;
         done_q     <= 1'b0;
         pre_q      <= 1'b0;
         bcd_q      <= to_bcd(Ambient);
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         sec_cnt_q  <= sec_cnt_d;
         tgt_q      <= tgt_d;
         cur_q      <= cur_d;
         min_q      <= min_d;
         heater_q   <= heater_d;
         done_q     <= done_d;
         pre_q      <= pre_d;
         bcd_q      <= to_bcd(cur_q);
      end
   end

   assign state     = state_q;
   assign cur_temp  = cur_q;
   assign temp_bcd  = bcd_q;
   assign min_left  = (state_q == StHold) ? min_q : 8'd0;
   assign heater_on = heater_q;
   assign done      = done_q;

`ifdef PREHEAT_DONE_EN
   assign preheat_done = pre_q;
`else
   logic unused_pre;
   assign unused_pre = pre_q;
`endif

endmodule
